// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage constants: ALU function codes, condition
// selectors and the condition-code reset value.
package y86_pkg;

  // ALU function encodings (alu_fun / add64 control)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Condition selectors (ifun of jXX / cmovXX)
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // Condition codes packed as {ZF,SF,OF}; reset leaves ZF set
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/add64.sv
// Combinational 64-bit ALU: add / sub (B - A) / and / xor with signed overflow.
import y86_pkg::*;

module add64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] S,
  output logic             overflow
);

  // Select the operation; overflow only meaningful for add/sub
  always_comb begin
    S        = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        S        = A + B;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        // Y86 subq rA,rB computes rB - rA
        S        = B - A;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (S[WIDTH-1] != B[WIDTH-1]);
      end
      ALU_AND: S = A & B;
      default: S = A ^ B;
    endcase
  end

endmodule

// File: rtl/cond_eval.sv
// Maps the condition codes and a condition selector to the jXX/cmovXX outcome.
import y86_pkg::*;

module cond_eval (
  input  logic [2:0] cc,
  input  logic [3:0] cond_fun,
  output logic       cnd,
  output logic       bad_cond
);

  logic zf;
  logic sf;
  logic of_flag;

  assign zf      = cc[2];
  assign sf      = cc[1];
  assign of_flag = cc[0];

  // Decode the selector; codes above C_G are flagged and never taken
  always_comb begin
    cnd      = 1'b0;
    bad_cond = 1'b0;
    case (cond_fun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of_flag) | zf;
      C_L:     cnd = sf ^ of_flag;
      C_E:     cnd = zf;
      C_NE:    cnd = !zf;
      C_GE:    cnd = !(sf ^ of_flag);
      C_G:     cnd = !(sf ^ of_flag) && !zf;
      default: bad_cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered Y86-64 execute stage: ALU, condition-code register, condition
// evaluation and a single-entry output register behind a valid/ready handshake.
import y86_pkg::*;

module alu_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [1:0]       alu_fun,
  input  logic             set_cc,
  input  logic [3:0]       cond_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             cnd,
  output logic [2:0]       cc_out,
  output logic             bad_cond
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val_e_q, val_e_d;
  logic             cnd_q, cnd_d;
  logic             bad_cond_q, bad_cond_d;
  logic [2:0]       cc_q, cc_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             cnd_comb;
  logic             bad_cond_comb;
  logic             accept;

  add64 #(.WIDTH(WIDTH)) u_add64 (
    .A        (alu_a),
    .B        (alu_b),
    .control  (alu_fun),
    .S        (alu_result),
    .overflow (alu_overflow)
  );

  // Condition uses the CC before this tuple's own update
  cond_eval u_cond_eval (
    .cc       (cc_q),
    .cond_fun (cond_fun),
    .cnd      (cnd_comb),
    .bad_cond (bad_cond_comb)
  );

  // The slot frees up when empty or when downstream drains it this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: load on accept, otherwise drain or hold
  always_comb begin
    out_valid_d = out_valid_q;
    val_e_d     = val_e_q;
    cnd_d       = cnd_q;
    bad_cond_d  = bad_cond_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      val_e_d     = alu_result;
      cnd_d       = cnd_comb;
      bad_cond_d  = bad_cond_comb;
      if (set_cc) begin
        cc_d = {(alu_result == '0), alu_result[WIDTH-1], alu_overflow};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      val_e_q     <= '0;
      cnd_q       <= 1'b0;
      bad_cond_q  <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      val_e_q     <= val_e_d;
      cnd_q       <= cnd_d;
      bad_cond_q  <= bad_cond_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign bad_cond  = bad_cond_q;
  assign cc_out    = cc_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed cases plus random traffic,
// expectations from a plain-arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] alu_a = '0;
  logic [63:0] alu_b = '0;
  logic [1:0]  alu_fun = 2'b00;
  logic        set_cc = 1'b0;
  logic [3:0]  cond_fun = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] val_e;
  logic        cnd;
  logic [2:0]  cc_out;
  logic        bad_cond;

  alu_exec_stage #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fun   (alu_fun),
    .set_cc    (set_cc),
    .cond_fun  (cond_fun),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .cnd       (cnd),
    .cc_out    (cc_out),
    .bad_cond  (bad_cond)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    logic        cnd;
    logic        bad;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] model_cc = 3'b100;   // {ZF,SF,OF}
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: condition truth from flag semantics
  function automatic logic cond_truth(input logic [2:0] cc, input logic [3:0] c, output logic badc);
    logic zf, lt;
    zf   = cc[2];
    lt   = cc[1] != cc[0];      // signed "less than" after a compare
    badc = 1'b0;
    case (c)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: begin badc = 1'b1; return 1'b0; end
    endcase
  endfunction

  // Reference: apply one accepted tuple, push its expected result, update CC
  task automatic model_accept(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                              input logic sc, input logic [3:0] c);
    exp_t e;
    logic signed [65:0] wa, wb, wide;
    logic [63:0] t;
    logic ovf, badc;
    wa = {{2{a[63]}}, a};
    wb = {{2{b[63]}}, b};
    ovf = 1'b0;
    case (f)
      2'b00: begin wide = wa + wb; t = wide[63:0]; ovf = (wide != {{2{t[63]}}, t}); end
      2'b01: begin wide = wb - wa; t = wide[63:0]; ovf = (wide != {{2{t[63]}}, t}); end
      2'b10: t = a & b;
      default: t = a ^ b;
    endcase
    e.cnd = cond_truth(model_cc, c, badc);
    e.bad = badc;
    e.val = t;
    sb_q.push_back(e);
    if (sc) model_cc = {(t == 64'd0), t[63], ovf};
  endtask

  // One clock of driving: note acceptance before the edge, record it after
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) model_accept(alu_a, alu_b, alu_fun, set_cc, cond_fun);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                      input logic sc, input logic [3:0] c);
    bit acc;
    int n;
    alu_a = a; alu_b = b; alu_fun = f; set_cc = sc; cond_fun = c;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 64'(n), 64'(0));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'(($urandom_range(0, 3)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: compare presented result with the scoreboard head every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("cc_out", 64'(cc_out), 64'(model_cc));
        check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && sb_q.size() != 0) begin
          check("val_e", val_e, sb_q[0].val);
          check("cnd", 64'(cnd), 64'(sb_q[0].cnd));
          check("bad_cond", 64'(bad_cond), 64'(sb_q[0].bad));
          if (out_ready) void'(sb_q.pop_front());
        end
        $display("cycle t=%0t v=%0b r=%0b val_e=%h cnd=%0b bad=%0b cc=%b", $time,
                 out_valid, out_ready, val_e, cnd, bad_cond, cc_out);
      end
    end
  end

  initial begin
    bit acc;
    // Reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_val_e", val_e, 64'd0);
    check("rst_cc", 64'(cc_out), 64'(3'b100));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_cnd", 64'(cnd), 64'(0));
    check("rst_bad", 64'(bad_cond), 64'(0));
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Add overflow then conditions l and le
    out_ready = 1'b1;
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 4'd0);
    send(64'd5, 64'd6, 2'b10, 1'b0, 4'd2);
    send(64'd5, 64'd6, 2'b10, 1'b0, 4'd1);
    idle(2);

    // Sub to zero, equal condition, then 50-30
    send(64'd50, 64'd50, 2'b01, 1'b1, 4'd0);
    send(64'd7, 64'd9, 2'b00, 1'b0, 4'd3);
    send(64'd30, 64'd50, 2'b01, 1'b1, 4'd0);
    idle(2);

    // Backpressure: first result held, second tuple waits 4 cycles
    out_ready = 1'b0;
    send(64'd1, 64'd1, 2'b00, 1'b1, 4'd0);
    alu_a = 64'd1; alu_b = 64'd0; alu_fun = 2'b11; set_cc = 1'b1; cond_fun = 4'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      check("stall_no_accept", 64'(acc), 64'(0));
    end
    out_ready = 1'b1;
    send(64'd1, 64'd0, 2'b11, 1'b1, 4'd0);
    send(64'hF0, 64'hFE, 2'b10, 1'b1, 4'd0);
    idle(3);

    // Invalid condition then always
    send(64'd3, 64'd4, 2'b00, 1'b0, 4'd9);
    send(64'd3, 64'd4, 2'b00, 1'b0, 4'd0);
    idle(2);

    // Reset mid-stall, asserted between edges
    out_ready = 1'b0;
    send(64'd100, 64'd1, 2'b01, 1'b1, 4'd0);
    #2;
    check("stall_valid_before_rst", 64'(out_valid), 64'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_cc", 64'(cc_out), 64'(3'b100));
    check("async_rst_val_e", val_e, 64'd0);
    sb_q.delete();
    model_cc = 3'b100;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        alu_a = rand_operand();
        alu_b = alu_a;
      end else begin
        alu_a = rand_operand();
        alu_b = rand_operand();
      end
      alu_fun  = 2'($urandom_range(0, 3));
      set_cc   = 1'($urandom_range(0, 1));
      cond_fun = 4'($urandom_range(0, 15));
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("final_drain", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered Y86-64 execute stage that consumes operand/function tuples produced by the decode stage.
- Each accepted tuple goes through the 64-bit ALU (add/sub/and/xor, same encoding as add64).
- The stage holds the architectural condition-code register (ZF/SF/OF), evaluates jXX/cmovXX conditions, and presents one registered result to the memory stage under a valid/ready handshake.

Parameters:
- WIDTH, 64, datapath width in bits. Only 64 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand tuple present
- in_ready  output  1  stage can accept a tuple this cycle
- alu_a  input  WIDTH  operand A (valA or immediate)
- alu_b  input  WIDTH  operand B (valB)
- alu_fun  input  2  ALU function: 00 add, 01 sub, 10 and, 11 xor
- set_cc  input  1  update CC from this operation
- cond_fun  input  4  condition selector (ifun) for cnd
- out_valid  output  1  result register holds a valid entry
- out_ready  input  1  downstream accepts the result
- val_e  output  WIDTH  ALU result
- cnd  output  1  condition outcome for this tuple
- cc_out  output  3  current CC as {ZF,SF,OF}
- bad_cond  output  1  cond_fun was 7..15 for this tuple

Behaviour:
- Reset (async, rst_n=0): out_valid=0, val_e=0, cnd=0, bad_cond=0, CC={ZF,SF,OF}=3'b100, so cc_out=3'b100.
- in_ready = !out_valid || out_ready. It is combinational with no dependency on in_valid.
- Accept condition: in_valid && in_ready at the rising edge.
- On accept, all outputs are registered; result appears the cycle after accept (latency 1).
- On accept, out_valid becomes 1. With no accept while out_valid && out_ready, out_valid becomes 0.
- Back-to-back: full throughput, one tuple per cycle, while out_ready=1.
- While out_valid && !out_ready: in_ready=0, and val_e/cnd/bad_cond/out_valid hold unchanged.
- Arithmetic is modulo 2^64, two's complement:
  - add: val_e = A + B
  - sub: val_e = B - A (Y86 subq rA,rB)
  - and: val_e = A & B
  - xor: val_e = A ^ B
- Overflow (t = computed result):
  - add: OF = (A[63]==B[63]) && (t[63]!=A[63])
  - sub: OF = (A[63]!=B[63]) && (t[63]!=B[63])
  - and/xor: OF = 0
- CC source values: ZF = (t==0), SF = t[63].
- CC is written only on accept with set_cc=1. Otherwise CC holds, including while stalled.
- cnd is evaluated on the CC value before this tuple's own update (cmov/jXX never set CC):
  - 0 always = 1
  - 1 le = (SF^OF)|ZF
  - 2 l = SF^OF
  - 3 e = ZF
  - 4 ne = !ZF
  - 5 ge = !(SF^OF)
  - 6 g = !(SF^OF) && !ZF
  - 7..15: cnd = 0, bad_cond = 1
- Simultaneous accept and drain (out_valid && out_ready && in_valid): the new tuple replaces the old one in the same edge, with no bubble.
- Reset mid-operation: the pending result is discarded, CC returns to 3'b100, and no partial state survives.
- Inputs are don't-care when in_valid=0. Neither state nor CC may change.

Decomposition:
- Shared package y86_pkg holds:
  - ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR 2-bit constants
  - C_YES/C_LE/C_L/C_E/C_NE/C_GE/C_G 4-bit constants
  - CC reset constant 3'b100
- Sub-module: the existing add64 (S, overflow, A, B, control) supplies the combinational result and OF, with the B-A operand convention for sub.
- cond_eval is a small combinational sub-module mapping (cc, cond_fun) to {cnd, bad_cond}. The stage itself owns the registers and handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, val_e=0, cc_out=3'b100, in_ready=1.
- Add overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, fun=add, set_cc=1 -> next cycle val_e=64'h8000_0000_0000_0000, then cc_out={0,1,1}. A following tuple with cond_fun=2 (l) gives cnd=0; cond_fun=1 (le) gives cnd=0.
- Sub to zero, then condition: A=50, B=50, fun=sub, set_cc=1 -> val_e=0 and CC={1,0,0}. Next tuple cond_fun=3 (e), set_cc=0 -> cnd=1 and CC unchanged. Then A=30, B=50, sub -> val_e=20.
- Backpressure: issue 3 tuples (A=1,B=1 add; A=1,B=0 xor; A=0xF0,B=0xFE and) with out_ready held 0 for 4 cycles -> first result 2 is held, in_ready=0, and CC shows only the first update. Release out_ready -> results 2, 1, 0xF0 drain in order, one per cycle, with no loss or duplication.
- Invalid condition: cond_fun=9 -> cnd=0, bad_cond=1. A following tuple with cond_fun=0 -> cnd=1, bad_cond=0.
- Reset mid-stall: with out_valid=1 and out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid=0 and cc_out=3'b100 immediately, with no clock edge needed.
